// File: rtl/lfsr_pkg.sv
// lfsr_pkg: default tap masks and width helpers shared by the LFSR blocks.
package lfsr_pkg;
    localparam logic [7:0]  TAPS_8  = 8'b1011_1000;
    localparam logic [9:0]  TAPS_10 = 10'b10_0100_0000;
    localparam logic [15:0] TAPS_16 = 16'b1101_0000_0000_1000;

    function automatic logic [63:0] all_ones(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction
endpackage

// File: rtl/lfsr_period_tracker.sv
// lfsr_period_tracker: counts steps from the current start value and pulses when the sequence returns to it.
module lfsr_period_tracker #(
    parameter int WIDTH = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             load,
    input  logic             recover,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] state_next,
    output logic [WIDTH-1:0] step_count,
    output logic             period_pulse
);
    logic [WIDTH-1:0] start;

    always_ff @(posedge clk) begin
        if (reset) begin
            start        <= RESET_VALUE;
            step_count   <= '0;
            period_pulse <= 1'b0;
        end else if (load) begin
            start        <= load_value;
            step_count   <= '0;
            period_pulse <= 1'b0;
        end else if (recover) begin
            start        <= '0;
            step_count   <= '0;
            period_pulse <= 1'b0;
        end else if (step) begin
            period_pulse <= state_next == start;
            step_count   <= (state_next == start) ? '0 : step_count + WIDTH'(1);
        end else begin
            period_pulse <= 1'b0;
        end
    end
endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci XNOR LFSR with seed load, lock-up recovery and period tracking.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter logic [WIDTH-1:0] TAPS = TAPS_10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] step_count,
    output logic             period_pulse,
    output logic             lockup
);
    localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));

    logic             fb;
    logic             locked;
    logic             step;
    logic             recover;
    logic [WIDTH-1:0] state_next;

    assign fb         = ~^(state & TAPS);
    assign state_next = {state[WIDTH-2:0], fb};
    assign locked     = state == ONES;
    assign step       = en && !load && !locked;
    // All-ones is the XNOR fixed point; escape to zero instead of sticking.
    assign recover    = en && !load && locked;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RESET_VALUE;
            lockup <= 1'b0;
        end else if (load) begin
            state  <= load_value;
            lockup <= 1'b0;
        end else if (recover) begin
            state  <= '0;
            lockup <= 1'b1;
        end else begin
            state  <= step ? state_next : state;
            lockup <= 1'b0;
        end
    end

    lfsr_period_tracker #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_tracker (
        .clk          (clk),
        .reset        (reset),
        .step         (step),
        .load         (load),
        .recover      (recover),
        .load_value   (load_value),
        .state_next   (state_next),
        .step_count   (step_count),
        .period_pulse (period_pulse)
    );
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: table vectors, directed period/lock-up sequences and random stimulus against a reference model.
module tb_lfsr_gen;
    localparam int W = 10;
    localparam logic [W-1:0] T = 10'b10_0100_0000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] state;
    logic [W-1:0] step_count;
    logic         period_pulse;
    logic         lockup;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] m_state, m_start, m_cnt;
    logic         m_pp, m_lu;

    typedef struct {
        bit           r, l, e;
        logic [W-1:0] lv, es, ec;
        bit           ep, el;
    } vec_t;

    vec_t tbl[17];

    lfsr_gen dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .load         (load),
        .load_value   (load_value),
        .state        (state),
        .step_count   (step_count),
        .period_pulse (period_pulse),
        .lockup       (lockup)
    );

    always #5 clk = ~clk;

    // Next value from the tap rule: parity of tapped ones, XNOR means even count gives 1.
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] s);
        int ones = 0;
        for (int i = 0; i < W; i++) if (s[i] && T[i]) ones++;
        return (s * 2 + ((ones % 2 == 0) ? 1 : 0)) % (1 << W);
    endfunction

    task automatic drive(input bit r, input bit l, input bit e, input logic [W-1:0] lv);
        logic [W-1:0] nxt;
        reset = r; load = l; en = e; load_value = lv;
        @(posedge clk);
        #1;
        m_pp = 0; m_lu = 0;
        if (r) begin
            m_state = 0; m_start = 0; m_cnt = 0;
        end else if (l) begin
            m_state = lv; m_start = lv; m_cnt = 0;
        end else if (e && m_state == (1 << W) - 1) begin
            m_state = 0; m_start = 0; m_cnt = 0; m_lu = 1;
        end else if (e) begin
            nxt = ref_next(m_state);
            m_state = nxt;
            if (nxt == m_start) begin m_pp = 1; m_cnt = 0; end
            else m_cnt = (m_cnt + 1) % (1 << W);
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] es, input logic [W-1:0] ec,
                         input bit ep, input bit el);
        vectors++;
        if (state !== es || step_count !== ec || period_pulse !== ep || lockup !== el) begin
            miscompares++;
            $display("FAIL %s: got state=%h cnt=%0d pp=%b lu=%b, want state=%h cnt=%0d pp=%b lu=%b",
                     name, state, step_count, period_pulse, lockup, es, ec, ep, el);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_state, m_cnt, m_pp, m_lu);
    endtask

    task automatic check_val(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        int pulses;
        int pulse_at;
        tbl[0]  = '{1, 0, 0, 10'h000, 10'h000, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 10'h000, 10'h001, 1, 0, 0};
        tbl[2]  = '{0, 0, 1, 10'h000, 10'h003, 2, 0, 0};
        tbl[3]  = '{0, 0, 1, 10'h000, 10'h007, 3, 0, 0};
        tbl[4]  = '{0, 0, 1, 10'h000, 10'h00F, 4, 0, 0};
        tbl[5]  = '{0, 0, 1, 10'h000, 10'h01F, 5, 0, 0};
        tbl[6]  = '{0, 0, 1, 10'h000, 10'h03F, 6, 0, 0};
        tbl[7]  = '{0, 0, 1, 10'h000, 10'h07F, 7, 0, 0};
        tbl[8]  = '{0, 0, 1, 10'h000, 10'h0FE, 8, 0, 0};
        tbl[9]  = '{0, 1, 0, 10'h3FF, 10'h3FF, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 10'h000, 10'h3FF, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 10'h000, 10'h3FF, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 10'h000, 10'h3FF, 0, 0, 0};
        tbl[13] = '{0, 0, 1, 10'h000, 10'h000, 0, 0, 1};
        tbl[14] = '{0, 0, 1, 10'h000, 10'h001, 1, 0, 0};
        tbl[15] = '{0, 1, 1, 10'h2A0, 10'h2A0, 0, 0, 0};
        tbl[16] = '{0, 0, 0, 10'h000, 10'h2A0, 0, 0, 0};

        m_state = 0; m_start = 0; m_cnt = 0; m_pp = 0; m_lu = 0;
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].r, tbl[i].l, tbl[i].e, tbl[i].lv);
            check($sformatf("table[%0d]", i), tbl[i].es, tbl[i].ec, tbl[i].ep, tbl[i].el);
        end

        // Freeze mid-sequence: en low holds state and count, then resumes.
        for (int i = 0; i < 5; i++) begin drive(0, 0, 1, 0); check_model("resume_a"); end
        for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0); check_model("freeze"); end
        for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 0); check_model("resume_b"); end

        // Full period from reset.
        drive(1, 0, 0, 0);
        check_model("period_reset");
        pulses = 0; pulse_at = -1;
        for (int i = 1; i <= 1023; i++) begin
            drive(0, 0, 1, 0);
            check_model("period_step");
            if (i == 1022) check_val("cnt_before_wrap", int'(step_count), 1022);
            if (period_pulse) begin pulses++; pulse_at = i; end
        end
        check_val("period_pulse_count", pulses, 1);
        check_val("period_pulse_step", pulse_at, 1023);
        check_val("period_end_state", int'(state), 0);

        // Period from a loaded seed.
        drive(0, 1, 0, 10'h155);
        check_model("seed_load");
        pulses = 0; pulse_at = -1;
        for (int i = 1; i <= 1023; i++) begin
            drive(0, 0, 1, 0);
            check_model("seed_step");
            if (period_pulse) begin pulses++; pulse_at = i; end
        end
        check_val("seed_pulse_count", pulses, 1);
        check_val("seed_pulse_step", pulse_at, 1023);
        check_val("seed_end_state", int'(state), 'h155);

        // Reset mid-sequence at step 500, then a full clean period.
        drive(1, 0, 0, 0);
        for (int i = 0; i < 500; i++) drive(0, 0, 1, 0);
        check_model("pre_reset_500");
        drive(1, 0, 1, 0);
        check("reset_mid", 10'h000, 10'h000, 0, 0);
        pulses = 0; pulse_at = -1;
        for (int i = 1; i <= 1023; i++) begin
            drive(0, 0, 1, 0);
            if (period_pulse) begin pulses++; pulse_at = i; end
        end
        check_val("after_reset_pulse_step", pulse_at, 1023);
        check_val("after_reset_pulse_count", pulses, 1);

        // Random mix of reset, load (sometimes all-ones) and enable.
        for (int i = 0; i < 4000; i++) begin
            bit r, l, e;
            logic [W-1:0] lv;
            r = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 99) < 5);
            e = ($urandom_range(0, 99) < 80);
            lv = ($urandom_range(0, 3) == 0) ? 10'h3FF : W'($urandom);
            drive(r, l, e, lv);
            check_model("random");
            if (period_pulse && lockup) check_val("pulse_exclusive", 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
